// File: rtl/vision_frame_scheduler.sv
// -----------------------------------------------------------------------------
// vision_frame_scheduler
//
// Shares one vision AI core between NUM_SRC pixel sources. A round-robin
// arbiter picks the next requesting source, the scheduler then walks the core
// through start -> pixel stream -> frame end, waits for the core result and
// reports it tagged with the owning source ID. A watchdog bounds the STREAM
// and WAIT phases so a stalled source or core cannot hang the pipeline.
//
// Optional feature macro: THREAT_IRQ_EN
//   Adds parameter IRQ_CONF_MIN, input irq_clear, outputs threat_irq and
//   threat_src. The default build (macro undefined) has none of these.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   src_req               per-source level frame request
//   src_pixel_data        per-source pixel byte, source i at [8i+7:8i]
//   src_pixel_valid       per-source pixel strobe
//   src_frame_end         per-source end-of-frame pulse
//   src_grant             one-hot stream grant
//   core_start            core start_processing pulse
//   core_frame_start      core frame_start pulse
//   core_pixel_data/valid pixels forwarded to the core (1-cycle latency)
//   core_frame_end        core frame_end pulse, aligned with last pixel
//   core_busy             core ai_busy, blocks arbitration
//   core_done             core processing_done pulse
//   core_detection        core detection_result
//   core_confidence       core confidence_score
//   res_valid             one-cycle result strobe
//   res_src_id            source owning the result / timed-out frame
//   res_detection         captured detection (held until next report)
//   res_confidence        captured confidence (held until next report)
//   err_timeout           one-cycle watchdog pulse
//   frames_done           completed frame counter (wraps)
//   sched_busy            high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module vision_frame_scheduler #(
  parameter int NUM_SRC        = 4,
  parameter int SRC_W          = 2,
  parameter int TIMEOUT_CYCLES = 65535
`ifdef THREAT_IRQ_EN
  ,
  parameter int IRQ_CONF_MIN   = 80
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_pixel_data,
  input  logic [NUM_SRC-1:0]   src_pixel_valid,
  input  logic [NUM_SRC-1:0]   src_frame_end,
  output logic [NUM_SRC-1:0]   src_grant,
  output logic                 core_start,
  output logic                 core_frame_start,
  output logic [7:0]           core_pixel_data,
  output logic                 core_pixel_valid,
  output logic                 core_frame_end,
  input  logic                 core_busy,
  input  logic                 core_done,
  input  logic [31:0]          core_detection,
  input  logic [7:0]           core_confidence,
  output logic                 res_valid,
  output logic [SRC_W-1:0]     res_src_id,
  output logic [31:0]          res_detection,
  output logic [7:0]           res_confidence,
  output logic                 err_timeout,
  output logic [15:0]          frames_done,
`ifdef THREAT_IRQ_EN
  input  logic                 irq_clear,
  output logic                 threat_irq,
  output logic [SRC_W-1:0]     threat_src,
`endif
  output logic                 sched_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_REPORT = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  // Last watchdog count before expiry: the counter starts at 0 on phase entry,
  // so expiry happens in the TIMEOUT_CYCLES-th cycle of the phase.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t               state_q;
  logic [SRC_W-1:0]     win_q;
  logic [SRC_W-1:0]     rr_ptr_q;
  logic [15:0]          wd_q;
  logic [NUM_SRC-1:0]   grant_q;
  logic                 core_start_q;
  logic                 core_frame_start_q;
  logic [7:0]           core_pixel_data_q;
  logic                 core_pixel_valid_q;
  logic                 core_frame_end_q;
  logic                 res_valid_q;
  logic [SRC_W-1:0]     res_src_id_q;
  logic [31:0]          res_det_q;
  logic [7:0]           res_conf_q;
  logic                 err_timeout_q;
  logic [15:0]          frames_done_q;
  logic                 sched_busy_q;

  logic                 arb_hit_s;
  logic [SRC_W-1:0]     arb_win_s;
  logic [SRC_W-1:0]     arb_idx_s;
  logic [7:0]           win_pix_s;
  logic                 win_pval_s;
  logic                 win_fend_s;
  logic [NUM_SRC-1:0]   win_onehot_s;
  logic                 wd_expired_s;

  // Round-robin search: scanning from farthest to nearest offset leaves the
  // nearest requester after the pointer as the final (winning) assignment.
  always_comb begin
    arb_hit_s = 1'b0;
    arb_win_s = '0;
    arb_idx_s = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      arb_idx_s = SRC_W'((int'(rr_ptr_q) + i) % NUM_SRC);
      arb_hit_s = arb_hit_s | src_req[arb_idx_s];
      arb_win_s = src_req[arb_idx_s] ? arb_idx_s : arb_win_s;
    end
  end

  // Select the granted source's pixel lane, strobe and frame end.
  always_comb begin
    win_pix_s    = 8'd0;
    win_pval_s   = 1'b0;
    win_fend_s   = 1'b0;
    win_onehot_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      win_onehot_s[i] = (win_q == SRC_W'(i));
      win_pix_s       = (win_q == SRC_W'(i)) ? src_pixel_data[8*i +: 8] : win_pix_s;
      win_pval_s      = (win_q == SRC_W'(i)) ? src_pixel_valid[i]       : win_pval_s;
      win_fend_s      = (win_q == SRC_W'(i)) ? src_frame_end[i]         : win_fend_s;
    end
  end

  assign wd_expired_s = (wd_q == WD_LAST);

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= S_IDLE;
      win_q              <= '0;
      rr_ptr_q           <= SRC_W'(NUM_SRC - 1);
      wd_q               <= 16'd0;
      grant_q            <= '0;
      core_start_q       <= 1'b0;
      core_frame_start_q <= 1'b0;
      core_pixel_data_q  <= 8'd0;
      core_pixel_valid_q <= 1'b0;
      core_frame_end_q   <= 1'b0;
      res_valid_q        <= 1'b0;
      res_src_id_q       <= '0;
      res_det_q          <= 32'd0;
      res_conf_q         <= 8'd0;
      err_timeout_q      <= 1'b0;
      frames_done_q      <= 16'd0;
      sched_busy_q       <= 1'b0;
    end else begin
      core_start_q       <= 1'b0;
      core_frame_start_q <= 1'b0;
      core_pixel_valid_q <= 1'b0;
      core_frame_end_q   <= 1'b0;
      res_valid_q        <= 1'b0;
      err_timeout_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_hit_s && !core_busy) begin
            win_q              <= arb_win_s;
            rr_ptr_q           <= arb_win_s;
            core_start_q       <= 1'b1;
            core_frame_start_q <= 1'b1;
            sched_busy_q       <= 1'b1;
            state_q            <= S_START;
          end else begin
            sched_busy_q <= 1'b0;
          end
        end
        S_START: begin
          grant_q <= win_onehot_s;
          wd_q    <= 16'd0;
          state_q <= S_STREAM;
        end
        S_STREAM: begin
          core_pixel_data_q  <= win_pix_s;
          core_pixel_valid_q <= win_pval_s;
          // A frame end wins over a same-cycle watchdog expiry.
          if (win_fend_s) begin
            core_frame_end_q <= 1'b1;
            grant_q          <= '0;
            wd_q             <= 16'd0;
            state_q          <= S_WAIT;
          end else if (wd_expired_s) begin
            core_frame_end_q <= 1'b1;
            grant_q          <= '0;
            err_timeout_q    <= 1'b1;
            res_src_id_q     <= win_q;
            state_q          <= S_DRAIN;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
        end
        S_WAIT: begin
          // A result arriving in the expiry cycle is still reported.
          if (core_done) begin
            res_det_q     <= core_detection;
            res_conf_q    <= core_confidence;
            res_src_id_q  <= win_q;
            res_valid_q   <= 1'b1;
            frames_done_q <= frames_done_q + 16'd1;
            state_q       <= S_REPORT;
          end else if (wd_expired_s) begin
            err_timeout_q <= 1'b1;
            res_src_id_q  <= win_q;
            sched_busy_q  <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
        end
        S_REPORT: begin
          sched_busy_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        S_DRAIN: begin
          // The core still owes a result for the aborted frame; swallow it.
          if (core_done) begin
            sched_busy_q <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            sched_busy_q <= 1'b1;
          end
        end
        default: begin
          grant_q      <= '0;
          sched_busy_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign src_grant        = grant_q;
  assign core_start       = core_start_q;
  assign core_frame_start = core_frame_start_q;
  assign core_pixel_data  = core_pixel_data_q;
  assign core_pixel_valid = core_pixel_valid_q;
  assign core_frame_end   = core_frame_end_q;
  assign res_valid        = res_valid_q;
  assign res_src_id       = res_src_id_q;
  assign res_detection    = res_det_q;
  assign res_confidence   = res_conf_q;
  assign err_timeout      = err_timeout_q;
  assign frames_done      = frames_done_q;
  assign sched_busy       = sched_busy_q;

`ifdef THREAT_IRQ_EN
  logic             irq_q;
  logic [SRC_W-1:0] irq_src_q;
  logic             irq_set_s;

  // Evaluated while REPORT presents the freshly captured result.
  assign irq_set_s = (state_q == S_REPORT) && (res_det_q != 32'd0) &&
                     (res_conf_q >= 8'(IRQ_CONF_MIN));

  // Sticky threat interrupt; a same-cycle set takes priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= 1'b0;
      irq_src_q <= '0;
    end else if (irq_set_s) begin
      irq_q     <= 1'b1;
      irq_src_q <= res_src_id_q;
    end else if (irq_clear) begin
      irq_q <= 1'b0;
    end
  end

  assign threat_irq = irq_q;
  assign threat_src = irq_src_q;
`endif

endmodule
